// File: rtl/mult_hilo_unit_pkg.sv
// Shared constants for the HI/LO shift-add multiplier: default operand width and FSM encodings.
package mult_hilo_unit_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    localparam logic [1:0] MULT_IDLE = 2'd0;
    localparam logic [1:0] MULT_BUSY = 2'd1;
    localparam logic [1:0] MULT_DONE = 2'd2;

endpackage : mult_hilo_unit_pkg

// File: rtl/mult_hilo_unit_shift_add_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the upper half,
// then shift {carry, accumulator} right by one.
module shift_add_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic               i_mplier_lsb,
    output logic [2*WIDTH-1:0] o_acc_next
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    logic [WIDTH:0] w_sum;

    // Carry out of the upper-half add lands in bit WIDTH and is shifted back in.
    assign w_sum      = {1'b0, i_acc[ACC_W-1:WIDTH]}
                      + (i_mplier_lsb ? {1'b0, i_mcand} : (WIDTH+1)'(0));
    assign o_acc_next = ACC_W'({w_sum, i_acc[WIDTH-1:0]} >> 1);

endmodule : shift_add_step

// File: rtl/mult_hilo_unit.sv
// Iterative MULT/MULTU unit owning HI/LO; one shift-add step per cycle, WIDTH cycles per product.
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_mult,
    input  logic             i_mult_sign,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] w_result;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [CNT_W-1:0] r_count;
    logic             r_negate;
    logic             r_busy;
    logic             r_done;
    logic             w_launch;
    logic             w_last;

    assign w_launch = i_start_mult && ((r_state == MULT_IDLE) || (r_state == MULT_DONE));
    assign w_last   = (r_state == MULT_BUSY) && (r_count == '0);

    // Signed operands are reduced to magnitudes; 0x80..0 negates to itself, read as unsigned.
    assign w_a_mag = (i_mult_sign && i_operand_a[WIDTH-1]) ? WIDTH'(~i_operand_a + WIDTH'(1))
                                                           : i_operand_a;
    assign w_b_mag = (i_mult_sign && i_operand_b[WIDTH-1]) ? WIDTH'(~i_operand_b + WIDTH'(1))
                                                           : i_operand_b;
    assign w_result = r_negate ? ACC_W'(~w_acc_next + ACC_W'(1)) : w_acc_next;

    shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc        (r_acc),
        .i_mcand      (r_mcand),
        .i_mplier_lsb (r_mplier[0]),
        .o_acc_next   (w_acc_next)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MULT_IDLE: if (i_start_mult) w_next_state = MULT_BUSY;
            MULT_BUSY: if (r_count == '0) w_next_state = MULT_DONE;
            MULT_DONE: w_next_state = i_start_mult ? MULT_BUSY : MULT_IDLE;
            default:   w_next_state = MULT_IDLE;
        endcase
    end

    // busy/done are registered copies of the next-state decode.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MULT_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == MULT_BUSY);
            r_done  <= (w_next_state == MULT_DONE);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_negate <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_launch) begin
            r_acc    <= '0;
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_count  <= CNT_W'(WIDTH - 1);
            r_negate <= i_mult_sign & (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]);
        end else if (r_state == MULT_BUSY) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                r_hi <= w_result[ACC_W-1:WIDTH];
                r_lo <= w_result[WIDTH-1:0];
            end else begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule : mult_hilo_unit
